// File: rtl/id_ex_stage_pkg.sv
// Shared MIPS decode constants and helpers for the ID/EX stage.
package id_ex_stage_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [2:0] LOAD_CLASS = 3'b100;

    // Logical immediates and LUI take a zero-extended immediate.
    function automatic logic is_zero_ext(input logic [5:0] opcode);
        return (opcode == OP_ANDI) || (opcode == OP_ORI) ||
               (opcode == OP_XORI) || (opcode == OP_LUI);
    endfunction

    // Every opcode in the 100xxx group is a load.
    function automatic logic is_load(input logic [5:0] opcode);
        return opcode[5:3] == LOAD_CLASS;
    endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detector.sv
// Load-use hazard detection between the instruction in EX and the one in ID.
module load_use_detector #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [ADDR_W-1:0] ex_rt,
    input  logic [ADDR_W-1:0] read_addr1,
    input  logic [ADDR_W-1:0] read_addr2,
    input  logic              if_valid,
    output logic              hazard
);

    assign hazard = ex_valid & ex_mem_read & (ex_rt != '0) &
                    ((ex_rt == read_addr1) | (ex_rt == read_addr2)) & if_valid;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: register read addressing, write-back bypass,
// immediate extension, load-use stall and the ID/EX pipeline register.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              flush,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [DATA_W-1:0] if_pc,
    output logic [ADDR_W-1:0] read_addr1,
    output logic [ADDR_W-1:0] read_addr2,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    input  logic              wb_wr_enable,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [ADDR_W-1:0] ex_rs,
    output logic [ADDR_W-1:0] ex_rt,
    output logic [ADDR_W-1:0] ex_rd,
    output logic [4:0]        ex_shamt,
    output logic [5:0]        ex_opcode,
    output logic [5:0]        ex_funct,
    output logic              ex_mem_read,
    output logic [31:0]       stall_count
);

    logic [5:0]        opcode;
    logic [DATA_W-1:0] operand1;
    logic [DATA_W-1:0] operand2;
    logic [DATA_W-1:0] imm_ext;
    logic              hazard;
    logic              bubble;

    assign opcode     = if_instr[31:26];
    assign read_addr1 = if_instr[25:21];
    assign read_addr2 = if_instr[20:16];

    // Bypass the same-cycle write-back; register $0 always reads as zero.
    always_comb begin
        operand1 = read_data1;
        operand2 = read_data2;
        if (read_addr1 == '0)
            operand1 = '0;
        else if (wb_wr_enable && (wb_addr == read_addr1))
            operand1 = wb_data;
        if (read_addr2 == '0)
            operand2 = '0;
        else if (wb_wr_enable && (wb_addr == read_addr2))
            operand2 = wb_data;
    end

    // Zero- or sign-extend the 16-bit immediate; the LUI shift is left to EX.
    always_comb begin
        imm_ext = '0;
        if (is_zero_ext(opcode))
            imm_ext = {{(DATA_W-16){1'b0}}, if_instr[15:0]};
        else
            imm_ext = {{(DATA_W-16){if_instr[15]}}, if_instr[15:0]};
    end

    load_use_detector #(
        .ADDR_W (ADDR_W)
    ) u_load_use_detector (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .read_addr1  (read_addr1),
        .read_addr2  (read_addr2),
        .if_valid    (if_valid),
        .hazard      (hazard)
    );

    // A taken branch/jump overrides the stall: the instruction is discarded anyway.
    assign stall  = enable & hazard & ~flush;
    assign bubble = flush | stall;

    // ID/EX pipeline register: hold when disabled, bubble on flush/stall, else capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs_data  <= '0;
            ex_rt_data  <= '0;
            ex_imm      <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_shamt    <= '0;
            ex_opcode   <= '0;
            ex_funct    <= '0;
            ex_mem_read <= 1'b0;
        end else if (enable) begin
            if (bubble) begin
                ex_valid    <= 1'b0;
                ex_pc       <= '0;
                ex_rs_data  <= '0;
                ex_rt_data  <= '0;
                ex_imm      <= '0;
                ex_rs       <= '0;
                ex_rt       <= '0;
                ex_rd       <= '0;
                ex_shamt    <= '0;
                ex_opcode   <= '0;
                ex_funct    <= '0;
                ex_mem_read <= 1'b0;
            end else begin
                ex_valid    <= if_valid;
                ex_pc       <= if_pc;
                ex_rs_data  <= operand1;
                ex_rt_data  <= operand2;
                ex_imm      <= imm_ext;
                ex_rs       <= read_addr1;
                ex_rt       <= read_addr2;
                ex_rd       <= if_instr[15:11];
                ex_shamt    <= if_instr[10:6];
                ex_opcode   <= opcode;
                ex_funct    <= if_instr[5:0];
                ex_mem_read <= is_load(opcode);
            end
        end
    end

    // Count stalled cycles; stall already implies enable, so it holds while frozen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_count <= '0;
        else if (stall)
            stall_count <= stall_count + 32'd1;
    end

endmodule
